hdmi_block_sampler: RTL
=======================

// Module: hdmi_block_sampler
// PURPOSE
//  Consumes the streaming HDMI pixel interface in the hdmi_clk domain. Reduces a window of the
//  incoming frame to an OUT_W x OUT_H image by 2^SHIFT_X x 2^SHIFT_Y box averaging.
//  Emits one framebuffer write per output pixel, for the LED-panel display logic to read.
// PARAMETERS
//  X_OFFSET  0   first sampled xaddr
//  Y_OFFSET  0   first sampled yaddr
//  OUT_W     64  output columns
//  OUT_H     32  output rows
//  SHIFT_X   2   log2 of block width in source pixels
//  SHIFT_Y   2   log2 of block height in source lines
// PORTS
//  clk         in   1          hdmi_clk, single clock domain
//  reset       in   1          asynchronous, active-high
//  hdmi_valid  in   1          TMDS lock/valid
//  vsync       in   1          frame sync, active-high
//  rgb_valid   in   1          r/g/b/xaddr/yaddr qualify a visible pixel
//  r, g, b     in   8 each     pixel colour
//  xaddr       in   12         pixel column
//  yaddr       in   12         pixel line
//  wr_en       out  1          framebuffer write strobe
//  wr_addr     out  AW         row*OUT_W+col; AW = $clog2(OUT_W*OUT_H)
//  wr_data     out  24         {r,g,b} averaged
//  frame_done  out  1          1-cycle pulse after last block of a frame is written
// BEHAVIOUR
//  - Reset: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, FSM=WAIT_VSYNC, accumulators cleared.
//  - FSM WAIT_VSYNC -> ACTIVE on vsync rising edge with hdmi_valid=1.
//    ACTIVE -> WAIT_VSYNC on hdmi_valid=0 (frame abandoned, no further writes, no frame_done).
//    A vsync rising edge in ACTIVE restarts the frame.
//  - In-window pixel: rgb_valid=1, dx=xaddr-X_OFFSET < OUT_W<<SHIFT_X, dy=yaddr-Y_OFFSET < OUT_H<<SHIFT_Y.
//    Both differences are unsigned; xaddr<X_OFFSET wraps large and is ignored.
//    col=dx>>SHIFT_X, sx=dx[SHIFT_X-1:0], row=dy>>SHIFT_Y, sy=dy[SHIFT_Y-1:0].
//  - Horizontal sum register per channel, width 8+SHIFT_X. Loaded at sx==0, added otherwise.
//  - Column accumulator RAM: OUT_W entries x 3 x (8+SHIFT_X+SHIFT_Y) bits.
//    On sx==max: cycle 0 reads RAM[col]; cycle 1 writes hsum (sy==0) or RAM[col]+hsum (sy>0).
//    Distinct cols per RMW, so no hazard even at SHIFT_X=0.
//  - On sx==max and sy==max: cycle 2 asserts wr_en for 1 cycle, with wr_addr=row*OUT_W+col.
//    wr_data per channel = total>>(SHIFT_X+SHIFT_Y), truncating.
//    Latency: last contributing pixel -> wr_en = 2 clk.
//  - frame_done pulses the cycle after the write for row=OUT_H-1, col=OUT_W-1.
//  - Out-of-window pixels, rgb_valid=0 and hsync have no effect on state.
//  - Gaps of rgb_valid mid-block are tolerated; blocks are keyed only by addresses.
//  - Reset mid-operation: immediate return to reset values; pending RMW/write discarded.
// CONFIGURATION
//  SAMPLER_AVERAGE_EN defined: box average as above.
//  Undefined: point sampling. Only the pixel with sx==0, sy==0 is kept per block.
//    The accumulator RAM holds 24-bit pixels, and the write occurs on the last pixel of the block.
//    Same 2-clk latency; the averaging adders are not built.
// STRUCTURE
//  - Shared include wrangler_defs.vh holds:
//      RGB width localparam (24)
//      HDMI address width (12)
//      FSM state encodings WAIT_VSYNC/ACTIVE
//  - Sub-module sampler_acc_ram: simple dual-port RAM with registered read, for iCE40 EBR.
//  - Control, address split and output stage stay in hdmi_block_sampler.
// TESTING (OUT_W=4, OUT_H=2, SHIFT_X=1, SHIFT_Y=1, offsets 0 unless stated)
//  1. Uniform frame r=0x40,g=0x80,b=0xC0 over 8x4 px after vsync
//     -> 8 writes, addr 0..7, data 0x4080C0; frame_done once, 1 clk after addr 7.
//  2. Block (0,0) pixels r=0x00,0x04,0x08,0x0C
//     -> wr_data[23:16]=0x06, wr_addr=0, 2 clk after 4th pixel.
//  3. X_OFFSET=2; pixels at xaddr 0,1 and xaddr 10
//     -> ignored; first write covers xaddr 2..3.
//  4. hdmi_valid dropped after 3 of 8 blocks
//     -> writes stop, no frame_done; next vsync -> full clean frame.
//  5. reset asserted on the cycle after the last pixel of block 0
//     -> no wr_en; all outputs 0 while reset high.
//  6. Without SAMPLER_AVERAGE_EN, block r=0x10,0x20,0x30,0x40
//     -> wr_data[23:16]=0x10.

Source files
------------

// File: rtl/hdmi_block_sampler_pkg.sv
// rtl/hdmi_block_sampler_pkg.sv - shared widths, FSM encoding and helpers for the HDMI block sampler
//
// Contents:
//   RGB_W       packed {r,g,b} pixel width
//   CH_W        single colour channel width
//   HDMI_AW     xaddr/yaddr width of the HDMI pixel stream
//   sampler_state_e  WAIT_VSYNC / ACTIVE frame tracking states
//   clog2_min1  address width helper that never returns zero
package hdmi_block_sampler_pkg;

  localparam int RGB_W   = 24;
  localparam int CH_W    = 8;
  localparam int HDMI_AW = 12;

  typedef enum logic [0:0] {
    WAIT_VSYNC = 1'b0,
    ACTIVE     = 1'b1
  } sampler_state_e;

  // Index width for a table of n entries; a one-entry table still needs a 1-bit index.
  function automatic int clog2_min1(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/hdmi_block_sampler_acc_ram.sv
// rtl/hdmi_block_sampler_acc_ram.sv - column accumulator RAM, simple dual port with registered read
//
// Ports:
//   clk_i      clock
//   rd_en_i    read strobe; rd_data_o updates on the following edge
//   rd_addr_i  read column
//   rd_data_o  registered read data (old contents on a same-address write)
//   wr_en_i    write strobe
//   wr_addr_i  write column
//   wr_data_i  write data
// No reset: contents are always written (first block line) before they are read,
// which keeps the array mappable onto block RAM.
module hdmi_block_sampler_acc_ram
  import hdmi_block_sampler_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 36,
  localparam int AW    = clog2_min1(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/hdmi_block_sampler.sv
// rtl/hdmi_block_sampler.sv - reduces an HDMI frame window to OUT_W x OUT_H framebuffer writes
//
// Build option: SAMPLER_AVERAGE_EN
//   defined   -> each output pixel is the truncated box average of its 2^SHIFT_X x 2^SHIFT_Y block
//   undefined -> point sampling: the top-left pixel of each block is kept, no averaging adders
//
// Ports (single clock domain, asynchronous active-high reset):
//   clk, reset        hdmi_clk and reset
//   hdmi_valid        TMDS lock; dropping it abandons the current frame
//   vsync             frame sync, rising edge starts (or restarts) a frame
//   rgb_valid         qualifies r/g/b/xaddr/yaddr
//   r, g, b           pixel colour
//   xaddr, yaddr      pixel column / line
//   wr_en             one-cycle framebuffer write strobe
//   wr_addr           row*OUT_W+col
//   wr_data           {r,g,b} of the reduced pixel
//   frame_done        one-cycle pulse after the last block of a frame is written
//
// Pipeline, keyed purely by pixel addresses:
//   cycle 0  pixel accepted; horizontal sum updated; on the last column of a block the
//            running line sum is captured and RAM[col] is read
//   cycle 1  RAM[col] <= line sum (first block line) or RAM[col] + line sum; on the last
//            block line the reduced pixel is registered for output
//   cycle 2  wr_en high
module hdmi_block_sampler
  import hdmi_block_sampler_pkg::*;
#(
  parameter  int X_OFFSET = 0,
  parameter  int Y_OFFSET = 0,
  parameter  int OUT_W    = 64,
  parameter  int OUT_H    = 32,
  parameter  int SHIFT_X  = 2,
  parameter  int SHIFT_Y  = 2,
  localparam int AW       = $clog2(OUT_W * OUT_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hdmi_valid,
  input  logic               vsync,
  input  logic               rgb_valid,
  input  logic [CH_W-1:0]    r,
  input  logic [CH_W-1:0]    g,
  input  logic [CH_W-1:0]    b,
  input  logic [HDMI_AW-1:0] xaddr,
  input  logic [HDMI_AW-1:0] yaddr,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [RGB_W-1:0]   wr_data,
  output logic               frame_done
);

`ifdef SAMPLER_AVERAGE_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  // Per-channel widths: horizontal line sum and column total. In point-sampling mode
  // both simply hold one 8-bit sample.
  localparam int HW    = AVG_EN ? CH_W + SHIFT_X : CH_W;
  localparam int ACC_W = AVG_EN ? CH_W + SHIFT_X + SHIFT_Y : CH_W;
  localparam int CW    = clog2_min1(OUT_W);
  localparam int RW    = clog2_min1(OUT_H);

  localparam logic [HDMI_AW-1:0] X_OFF   = HDMI_AW'(X_OFFSET);
  localparam logic [HDMI_AW-1:0] Y_OFF   = HDMI_AW'(Y_OFFSET);
  // One extra bit so a window spanning the whole 4096-wide address space still compares.
  localparam logic [HDMI_AW:0]   WIN_W   = (HDMI_AW + 1)'(OUT_W << SHIFT_X);
  localparam logic [HDMI_AW:0]   WIN_H   = (HDMI_AW + 1)'(OUT_H << SHIFT_Y);
  localparam logic [HDMI_AW-1:0] SX_MASK = HDMI_AW'((1 << SHIFT_X) - 1);
  localparam logic [HDMI_AW-1:0] SY_MASK = HDMI_AW'((1 << SHIFT_Y) - 1);
  localparam logic [AW-1:0]      LAST_ADDR = AW'(OUT_W * OUT_H - 1);

  // ---------------------------------------------------------------- frame FSM
  sampler_state_e state_q, state_d;
  logic           vsync_q;
  logic           vsync_rise;
  logic           abandon;
  logic           pix_ok;

  assign vsync_rise = vsync & ~vsync_q;

  // A vsync edge while ACTIVE needs no action: blocks restart from their sx==0 / sy==0
  // pixels, which reload the line sum and the column total.
  always_comb begin
    state_d = state_q;
    abandon = 1'b0;
    pix_ok  = 1'b0;
    case (state_q)
      WAIT_VSYNC: begin
        if (vsync_rise && hdmi_valid) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!hdmi_valid) begin
          state_d = WAIT_VSYNC;
          abandon = 1'b1;
        end else begin
          pix_ok = rgb_valid;
        end
      end
      default: state_d = WAIT_VSYNC;
    endcase
  end

  // ---------------------------------------------------------------- address split
  logic [HDMI_AW-1:0] dx, dy;
  logic               in_win;
  logic               sx_zero, sx_max, sy_zero, sy_max;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;

  // Unsigned differences: addresses left of / above the offset wrap to large values
  // and fall outside the window.
  assign dx      = xaddr - X_OFF;
  assign dy      = yaddr - Y_OFF;
  assign in_win  = pix_ok && ({1'b0, dx} < WIN_W) && ({1'b0, dy} < WIN_H);
  assign sx_zero = (dx & SX_MASK) == '0;
  assign sx_max  = (dx & SX_MASK) == SX_MASK;
  assign sy_zero = (dy & SY_MASK) == '0;
  assign sy_max  = (dy & SY_MASK) == SY_MASK;
  assign col     = CW'(dx >> SHIFT_X);
  assign row     = RW'(dy >> SHIFT_Y);

  // ---------------------------------------------------------------- horizontal stage
  logic [2:0][CH_W-1:0] pix;
  logic [2:0][HW-1:0]   hsum_q, hsum_d, hnew;

  assign pix = {r, g, b};

  // hnew is the line sum including the current pixel; it is what gets handed to the
  // column stage on the last pixel of a block line.
  generate
    if (AVG_EN) begin : g_hsum_avg
      always_comb begin
        for (int c = 0; c < 3; c++) begin
          hnew[c] = sx_zero ? HW'(pix[c]) : hsum_q[c] + HW'(pix[c]);
        end
      end
    end else begin : g_hsum_point
      always_comb begin
        for (int c = 0; c < 3; c++) begin
          hnew[c] = sx_zero ? HW'(pix[c]) : hsum_q[c];
        end
      end
    end
  endgenerate

  assign hsum_d = in_win ? hnew : hsum_q;

  // ---------------------------------------------------------------- column stage
  logic               s1_valid_q;
  logic               s1_first_q;
  logic               s1_last_q;
  logic [CW-1:0]      s1_col_q;
  logic [RW-1:0]      s1_row_q;
  logic [2:0][HW-1:0] s1_h_q;

  logic                  launch;
  logic                  ram_we;
  logic [2:0][ACC_W-1:0] ram_rd;
  logic [2:0][ACC_W-1:0] acc_sum;
  logic [2:0][CH_W-1:0]  blk_pix;
  logic [AW-1:0]         blk_addr;

  assign launch = in_win & sx_max;
  assign ram_we = s1_valid_q & ~abandon;

  generate
    if (AVG_EN) begin : g_acc_avg
      always_comb begin
        for (int c = 0; c < 3; c++) begin
          acc_sum[c] = s1_first_q ? ACC_W'(s1_h_q[c]) : ram_rd[c] + ACC_W'(s1_h_q[c]);
        end
      end
    end else begin : g_acc_point
      // Only the first block line's sample is stored; later lines write it back unchanged.
      always_comb begin
        for (int c = 0; c < 3; c++) begin
          acc_sum[c] = s1_first_q ? ACC_W'(s1_h_q[c]) : ram_rd[c];
        end
      end
    end
  endgenerate

  // Dropping the low SHIFT_X+SHIFT_Y bits divides by the block area (zero in point mode).
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      blk_pix[c] = CH_W'(acc_sum[c] >> (ACC_W - CH_W));
    end
  end

  assign blk_addr = AW'(s1_row_q) * AW'(OUT_W) + AW'(s1_col_q);

  hdmi_block_sampler_acc_ram #(
    .DEPTH (OUT_W),
    .WIDTH (3 * ACC_W)
  ) u_acc_ram (
    .clk_i     (clk),
    .rd_en_i   (launch),
    .rd_addr_i (col),
    .rd_data_o (ram_rd),
    .wr_en_i   (ram_we),
    .wr_addr_i (s1_col_q),
    .wr_data_i (acc_sum)
  );

  // ---------------------------------------------------------------- registers
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [RGB_W-1:0] wr_data_q;
  logic             frame_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_VSYNC;
      vsync_q      <= 1'b0;
      hsum_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      s1_h_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync;
      hsum_q     <= hsum_d;
      s1_valid_q <= launch;
      if (launch) begin
        s1_first_q <= sy_zero;
        s1_last_q  <= sy_max;
        s1_col_q   <= col;
        s1_row_q   <= row;
        s1_h_q     <= hnew;
      end
      // A frame abandoned while a block is in flight produces no write.
      wr_en_q <= s1_valid_q & s1_last_q & ~abandon;
      if (s1_valid_q && s1_last_q) begin
        wr_addr_q <= blk_addr;
        wr_data_q <= blk_pix;
      end
      frame_done_q <= wr_en_q && (wr_addr_q == LAST_ADDR);
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;

endmodule
